// File: rtl/mq_pass_scheduler_if.sv
// Handshake bundle between code-block fetch control, the word-last generator,
// the MQ side and the pass scheduler.
interface mq_pass_scheduler_if #(
    parameter int unsigned PLANE_W = 4
);
    logic               cb_start;
    logic [PLANE_W-1:0] cb_num_planes;
    logic               word_last_sp;
    logic               word_last_mrp;
    logic               word_last_cp;
    logic               bp_code_over;
    logic               pass_start;
    logic [1:0]         pass_type;
    logic [PLANE_W-1:0] plane_idx;
    logic               flush_req;
    logic               busy;
    logic               cb_done;
    logic [PLANE_W+1:0] pass_cnt;

    // Control/datapath side: issues blocks, reports pass and flush completion.
    modport master (
        output cb_start, cb_num_planes, word_last_sp, word_last_mrp, word_last_cp,
               bp_code_over,
        input  pass_start, pass_type, plane_idx, flush_req, busy, cb_done, pass_cnt
    );

    // Scheduler side.
    modport slave (
        input  cb_start, cb_num_planes, word_last_sp, word_last_mrp, word_last_cp,
               bp_code_over,
        output pass_start, pass_type, plane_idx, flush_req, busy, cb_done, pass_cnt
    );
endinterface

// File: rtl/mq_pass_scheduler.sv
// Coding-pass sequencer for one code block: walks bit-planes MSB->LSB issuing
// CP on the top plane and SP/MRP/CP on each lower plane, then flushes the MQ coder.
module mq_pass_scheduler #(
    parameter int unsigned PLANE_W = 4
) (
    input logic                   clk,
    input logic                   rst_syn,
    mq_pass_scheduler_if.slave    bus
);
    localparam logic [1:0] PassNone = 2'b00;
    localparam logic [1:0] PassSp   = 2'b01;
    localparam logic [1:0] PassMrp  = 2'b10;
    localparam logic [1:0] PassCp   = 2'b11;

    localparam logic [PLANE_W-1:0] PlaneOne = PLANE_W'(1);
    localparam logic [PLANE_W+1:0] CntOne   = (PLANE_W + 2)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPassStart,
        StPassWait,
        StFlushReq,
        StFlushWait,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         type_q, type_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [PLANE_W+1:0] cnt_q, cnt_d;
    logic               sp_prev_q, mrp_prev_q, cp_prev_q;
    logic               pass_done;

    // State, pass bookkeeping and flag history registers.
    always_ff @(posedge clk) begin
        if (rst_syn) begin
            state_q    <= StIdle;
            type_q     <= PassNone;
            plane_q    <= '0;
            cnt_q      <= '0;
            sp_prev_q  <= 1'b0;
            mrp_prev_q <= 1'b0;
            cp_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            plane_q    <= plane_d;
            cnt_q      <= cnt_d;
            sp_prev_q  <= bus.word_last_sp;
            mrp_prev_q <= bus.word_last_mrp;
            cp_prev_q  <= bus.word_last_cp;
        end
    end

    // Completion is a rising edge of the flag belonging to the current pass only.
    always_comb begin
        pass_done = 1'b0;
        unique case (type_q)
            PassSp:  pass_done = bus.word_last_sp  & ~sp_prev_q;
            PassMrp: pass_done = bus.word_last_mrp & ~mrp_prev_q;
            PassCp:  pass_done = bus.word_last_cp  & ~cp_prev_q;
            default: pass_done = 1'b0;
        endcase
    end

    // Next-state and pass sequencing.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        plane_d = plane_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cb_start) begin
                    cnt_d = '0;
                    if (bus.cb_num_planes != '0) begin
                        plane_d = bus.cb_num_planes - PlaneOne;
                        type_d  = PassCp;
                        state_d = StPassStart;
                    end else begin
                        type_d  = PassNone;
                        state_d = StDone;
                    end
                end
            end
            StPassStart: state_d = StPassWait;
            StPassWait: begin
                if (pass_done) begin
                    cnt_d   = cnt_q + CntOne;
                    state_d = StPassStart;
                    if (type_q == PassSp) begin
                        type_d = PassMrp;
                    end else if (type_q == PassMrp) begin
                        type_d = PassCp;
                    end else if (plane_q != '0) begin
                        plane_d = plane_q - PlaneOne;
                        type_d  = PassSp;
                    end else begin
                        type_d  = PassNone;
                        state_d = StFlushReq;
                    end
                end
            end
            StFlushReq:  state_d = StFlushWait;
            StFlushWait: if (bus.bp_code_over) state_d = StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    assign bus.pass_start = (state_q == StPassStart);
    assign bus.flush_req  = (state_q == StFlushReq);
    assign bus.cb_done    = (state_q == StDone);
    assign bus.busy       = (state_q != StIdle);
    assign bus.pass_type  = type_q;
    assign bus.plane_idx  = plane_q;
    assign bus.pass_cnt   = cnt_q;
endmodule
